// File: rtl/multicycle_sub_if.sv
// Request/response bundle for the digit-serial subtractor.
// The slave side is the subtractor; the master side is whoever feeds it operands.
interface multicycle_sub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport slave (
    input  in_valid, a, b, mode, bin, out_ready,
    output in_ready, out_valid, result, bout, ovf, zero
  );

  modport master (
    output in_valid, a, b, mode, bin, out_ready,
    input  in_ready, out_valid, result, bout, ovf, zero
  );
endinterface

// File: rtl/multicycle_sub.sv
// Digit-serial subtractor: DIGIT bits of (opX - opY - borrow) per cycle, LSB digit first,
// with valid/ready on both sides and result flags held until the next completion.
module multicycle_sub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input logic             clk,
  input logic             rst_n,
  multicycle_sub_if.slave bus
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ModeSbb  = 2'b01;
  localparam logic [1:0] ModeRsub = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] opx_q, opx_d;
  logic [WIDTH-1:0] opy_q, opy_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Operands shift right each cycle, so the active digit is always in the low DIGIT bits.
  logic [DIGIT-1:0] dx, dy;
  logic [DIGIT:0]   ddiff;
  logic [WIDTH-1:0] acc_next;
  logic             last_digit;

  always_comb begin
    dx         = opx_q[DIGIT-1:0];
    dy         = opy_q[DIGIT-1:0];
    ddiff      = {1'b0, dx} - {1'b0, dy} - {{DIGIT{1'b0}}, borrow_q};
    // New digit enters at the top; after N cycles the first digit has reached bit 0.
    acc_next   = (acc_q >> DIGIT) | (WIDTH'(ddiff[DIGIT-1:0]) << (WIDTH - DIGIT));
    last_digit = (cnt_q == CntW'(N - 1));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    opx_d    = opx_q;
    opy_d    = opy_q;
    acc_d    = acc_q;
    result_d = result_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          opx_d    = (bus.mode == ModeRsub) ? bus.b : bus.a;
          opy_d    = (bus.mode == ModeRsub) ? bus.a : bus.b;
          borrow_d = (bus.mode == ModeSbb) ? bus.bin : 1'b0;
          cnt_d    = '0;
          acc_d    = '0;
          state_d  = StRun;
        end
      end

      StRun: begin
        opx_d    = opx_q >> DIGIT;
        opy_d    = opy_q >> DIGIT;
        acc_d    = acc_next;
        borrow_d = ddiff[DIGIT];
        cnt_d    = cnt_q + CntW'(1);
        if (last_digit) begin
          // dx/dy hold the operand MSB digit here, so their top bits are the sign bits.
          result_d = acc_next;
          bout_d   = ddiff[DIGIT];
          ovf_d    = (dx[DIGIT-1] != dy[DIGIT-1]) && (ddiff[DIGIT-1] != dx[DIGIT-1]);
          zero_d   = (acc_next == '0);
          cnt_d    = '0;
          state_d  = StDone;
        end
      end

      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      opx_q    <= '0;
      opy_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      opx_q    <= opx_d;
      opy_q    <= opy_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_multicycle_sub.sv
// Randomized bench for multicycle_sub (32/8 and 16/1) against a whole-word arithmetic model.
module tb_multicycle_sub;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multicycle_sub_if #(.WIDTH(32)) bus1 ();
  multicycle_sub_if #(.WIDTH(16)) bus2 ();

  multicycle_sub #(.WIDTH(32), .DIGIT(8)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  multicycle_sub #(.WIDTH(16), .DIGIT(1)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word subtraction on 64-bit values, masked to w bits.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic [1:0] m, input logic bin,
                                output logic [63:0] res, output logic bo, output logic ov,
                                output logic z);
    logic [63:0] mask, x, y, bi;
    mask = (64'd1 << w) - 64'd1;
    x    = (m == 2'b10) ? b : a;
    y    = (m == 2'b10) ? a : b;
    bi   = (m == 2'b01) ? {63'd0, bin} : 64'd0;
    res  = (x - y - bi) & mask;
    bo   = (x < y + bi);
    ov   = (x[w-1] != y[w-1]) && (res[w-1] != x[w-1]);
    z    = (res == 64'd0);
  endfunction

  task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                         input logic bi);
    bus1.in_valid = 1'b1;
    bus1.a        = a;
    bus1.b        = b;
    bus1.mode     = m;
    bus1.bin      = bi;
  endtask

  // Expects operands already driven with in_valid=1 and the DUT idle before the next posedge.
  task automatic finish32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                          input logic bi, input int hold);
    logic [63:0] er;
    logic        eb, eo, ez;
    int          lat;
    model(32, 64'(a), 64'(b), m, bi, er, eb, eo, ez);
    @(posedge clk); #1;
    check("busy_after_accept", 64'(bus1.in_ready), 64'd0);
    lat = 0;
    while (!bus1.out_valid && lat < 64) begin
      bus1.in_valid = 1'($urandom);
      bus1.a        = $urandom;
      bus1.b        = $urandom;
      bus1.mode     = 2'($urandom);
      bus1.bin      = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    check("latency32", 64'(lat), 64'd4);
    check("result32", 64'(bus1.result), er);
    check("bout32", 64'(bus1.bout), 64'(eb));
    check("ovf32", 64'(bus1.ovf), 64'(eo));
    check("zero32", 64'(bus1.zero), 64'(ez));
    for (int i = 0; i < hold; i++) begin
      bus1.in_valid = 1'($urandom);
      bus1.a        = $urandom;
      bus1.b        = $urandom;
      @(posedge clk); #1;
      check("hold_valid", 64'(bus1.out_valid), 64'd1);
      check("hold_result", 64'(bus1.result), er);
      check("hold_in_ready", 64'(bus1.in_ready), 64'd0);
    end
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    check("drain_valid", 64'(bus1.out_valid), 64'd0);
    check("drain_in_ready", 64'(bus1.in_ready), 64'd1);
    check("drain_result_held", 64'(bus1.result), er);
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                      input logic bi, input int hold);
    @(negedge clk);
    drive32(a, b, m, bi);
    finish32(a, b, m, bi, hold);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                      input logic bi);
    logic [63:0] er;
    logic        eb, eo, ez;
    int          lat;
    model(16, 64'(a), 64'(b), m, bi, er, eb, eo, ez);
    @(negedge clk);
    bus2.in_valid = 1'b1;
    bus2.a        = a;
    bus2.b        = b;
    bus2.mode     = m;
    bus2.bin      = bi;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    lat = 0;
    while (!bus2.out_valid && lat < 100) begin
      bus2.a = 16'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    check("latency16", 64'(lat), 64'd16);
    check("result16", 64'(bus2.result), er);
    check("bout16", 64'(bus2.bout), 64'(eb));
    check("ovf16", 64'(bus2.ovf), 64'(eo));
    check("zero16", 64'(bus2.zero), 64'(ez));
    bus2.out_ready = 1'b1;
    @(posedge clk); #1;
    bus2.out_ready = 1'b0;
    check("drain16_in_ready", 64'(bus2.in_ready), 64'd1);
  endtask

  function automatic logic [31:0] pick32();
    logic [31:0] corner [5];
    corner = '{32'h0, 32'h1, 32'h7fff_ffff, 32'h8000_0000, 32'hffff_ffff};
    if ($urandom_range(0, 2) == 0) return corner[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.a         = '0;
    bus1.b         = '0;
    bus1.mode      = '0;
    bus1.bin       = 1'b0;
    bus1.out_ready = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.a         = '0;
    bus2.b         = '0;
    bus2.mode      = '0;
    bus2.bin       = 1'b0;
    bus2.out_ready = 1'b0;
    #2;
    check("rst_out_valid", 64'(bus1.out_valid), 64'd0);
    check("rst_result", 64'(bus1.result), 64'd0);
    check("rst_bout", 64'(bus1.bout), 64'd0);
    check("rst_ovf", 64'(bus1.ovf), 64'd0);
    check("rst_zero", 64'(bus1.zero), 64'd0);
    check("rst_in_ready", 64'(bus1.in_ready), 64'd1);
    check("rst_in_ready16", 64'(bus2.in_ready), 64'd1);

    // Accept on the very first edge after reset release.
    @(negedge clk);
    drive32(32'd5, 32'd3, 2'b00, 1'b0);
    rst_n = 1'b1;
    finish32(32'd5, 32'd3, 2'b00, 1'b0, 0);

    op32(32'd0, 32'd1, 2'b00, 1'b0, 0);
    op32(32'h8000_0000, 32'd1, 2'b00, 1'b0, 1);
    op32(32'd5, 32'd5, 2'b01, 1'b1, 0);
    op32(32'd5, 32'd5, 2'b01, 1'b0, 0);
    op32(32'd3, 32'd10, 2'b10, 1'b0, 0);
    op32(32'd7, 32'd2, 2'b11, 1'b1, 0);
    op32(32'h1234_5678, 32'h0fed_cba9, 2'b00, 1'b0, 5);

    // Reset pulse while digit 2 is in flight.
    op32(32'd5, 32'd3, 2'b00, 1'b0, 0);
    @(negedge clk);
    drive32(32'h0000_0100, 32'd1, 2'b00, 1'b0);
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_valid", 64'(bus1.out_valid), 64'd0);
    check("midrun_rst_in_ready", 64'(bus1.in_ready), 64'd1);
    check("midrun_rst_result", 64'(bus1.result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op32(32'd9, 32'd4, 2'b00, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      op32(pick32(), pick32(), 2'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    op16(16'h0001, 16'h0002, 2'b00, 1'b0);
    for (int n = 0; n < 4; n++) begin
      op16(16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
